// File: rtl/scan_code_digit_entry_if.sv
// Bus between the PS/2 byte receiver (master) and the digit-entry block (slave).
// Carries the scan-code strobe in and the edited/committed entry back out.
interface scan_code_digit_entry_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int ENTRY_W = 4 * NUM_DIGITS;
  localparam int CNT_W   = $clog2(NUM_DIGITS + 1);

  logic [7:0]         scan_code_in;
  logic               scan_valid;
  logic [3:0]         digit_out;
  logic [ENTRY_W-1:0] entry_out;
  logic [CNT_W-1:0]   digit_count;
  logic [ENTRY_W-1:0] value_out;
  logic               value_valid;
  logic               overflow;

  modport master (
    output scan_code_in, scan_valid,
    input  digit_out, entry_out, digit_count, value_out, value_valid, overflow
  );

  modport slave (
    input  scan_code_in, scan_valid,
    output digit_out, entry_out, digit_count, value_out, value_valid, overflow
  );
endinterface

// File: rtl/scan_code_digit_entry.sv
// PS/2 set-2 scan-code digit entry: tracks F0/E0 prefixes, shifts decoded
// digits into an editable entry (newest digit in the low nibble), supports
// backspace, and commits the entry to value_out on Enter or keypad Enter.
module scan_code_digit_entry #(
  parameter int NUM_DIGITS = 4,
  parameter bit HEX_EN     = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  scan_code_digit_entry_if.slave bus
);
  localparam int ENTRY_W = 4 * NUM_DIGITS;
  localparam int CNT_W   = $clog2(NUM_DIGITS + 1);

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [7:0] CODE_BKSP  = 8'h66;
  localparam logic [7:0] CODE_NULL  = 8'h00;

  localparam logic [3:0] DIGIT_NONE    = 4'hF;
  localparam logic [3:0] DIGIT_UNKNOWN = 4'hA;

  typedef enum logic [1:0] {IDLE, BRK, EXT} state_e;

  // Returns {hit, value}; letters only hit when hex entry is enabled.
  function automatic logic [4:0] decode_digit(input logic [7:0] code);
    case (code)
      8'h45:   return {1'b1, 4'h0};
      8'h16:   return {1'b1, 4'h1};
      8'h1E:   return {1'b1, 4'h2};
      8'h26:   return {1'b1, 4'h3};
      8'h25:   return {1'b1, 4'h4};
      8'h2E:   return {1'b1, 4'h5};
      8'h36:   return {1'b1, 4'h6};
      8'h3D:   return {1'b1, 4'h7};
      8'h3E:   return {1'b1, 4'h8};
      8'h46:   return {1'b1, 4'h9};
      8'h1C:   return {HEX_EN, 4'hA};
      8'h32:   return {HEX_EN, 4'hB};
      8'h21:   return {HEX_EN, 4'hC};
      8'h23:   return {HEX_EN, 4'hD};
      8'h24:   return {HEX_EN, 4'hE};
      8'h2B:   return {HEX_EN, 4'hF};
      default: return 5'b0;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [3:0]         digit_q, digit_d;
  logic [ENTRY_W-1:0] value_q, value_d;
  logic               value_valid_q, value_valid_d;
  logic               overflow_q, overflow_d;

  logic [4:0]         dec;
  logic               do_make;
  logic               do_enter;

  // Prefix tracking plus the make-code action on the entry registers.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d       = state_q;
    entry_d       = entry_q;
    count_d       = count_q;
    digit_d       = digit_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    overflow_d    = overflow_q;
    do_make       = 1'b0;
    do_enter      = 1'b0;
    dec           = decode_digit(bus.scan_code_in);

    if (bus.scan_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.scan_code_in == CODE_BREAK)    state_d = BRK;
          else if (bus.scan_code_in == CODE_EXT) state_d = EXT;
          else                                   do_make = 1'b1;
        end
        BRK: state_d = IDLE;  // released key byte is swallowed
        EXT: begin
          state_d  = (bus.scan_code_in == CODE_BREAK) ? BRK : IDLE;
          do_enter = (bus.scan_code_in == CODE_ENTER);
        end
        default: state_d = IDLE;
      endcase
    end

    if (do_make) begin
      if (bus.scan_code_in == CODE_ENTER) begin
        do_enter = 1'b1;
      end else if (bus.scan_code_in == CODE_BKSP) begin
        if (count_q != '0) begin
          entry_d = entry_q >> 4;
          count_d = count_q - CNT_W'(1);
        end
      end else if (bus.scan_code_in == CODE_NULL) begin
        digit_d = DIGIT_NONE;
      end else if (dec[4]) begin
        digit_d = dec[3:0];
        if (count_q < CNT_W'(NUM_DIGITS)) begin
          entry_d = (entry_q << 4) | ENTRY_W'(dec[3:0]);
          count_d = count_q + CNT_W'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        digit_d = DIGIT_UNKNOWN;
      end
    end

    if (do_enter) begin
      value_d       = entry_q;
      value_valid_d = 1'b1;
      entry_d       = '0;
      count_d       = '0;
      overflow_d    = 1'b0;
      digit_d       = DIGIT_NONE;
    end
  end

  // State and output registers; reset discards any pending prefix.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      entry_q       <= '0;
      count_q       <= '0;
      digit_q       <= DIGIT_NONE;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q       <= state_d;
      entry_q       <= entry_d;
      count_q       <= count_d;
      digit_q       <= digit_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.digit_out   = digit_q;
  assign bus.entry_out   = entry_q;
  assign bus.digit_count = count_q;
  assign bus.value_out   = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_scan_code_digit_entry.sv
// Bench for scan_code_digit_entry: a decimal and a hex instance share one byte
// stream; a list-of-digits model per instance is compared every cycle, and
// literal expectations pin the model at key points.
module tb_scan_code_digit_entry;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sc  = 8'h00;
  logic       sv  = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scan_code_digit_entry_if #(.NUM_DIGITS(N)) bus0 ();
  scan_code_digit_entry_if #(.NUM_DIGITS(N)) bus1 ();
  assign bus0.scan_code_in = sc;
  assign bus0.scan_valid   = sv;
  assign bus1.scan_code_in = sc;
  assign bus1.scan_valid   = sv;

  scan_code_digit_entry #(.NUM_DIGITS(N), .HEX_EN(1'b0)) u_dec (.clk(clk), .rst(rst), .bus(bus0));
  scan_code_digit_entry #(.NUM_DIGITS(N), .HEX_EN(1'b1)) u_hex (.clk(clk), .rst(rst), .bus(bus1));

  // Behavioural model: digits held as a list, oldest first.
  typedef struct packed {
    logic            brk;
    logic            ext;
    logic [3:0]      cnt;
    logic [7:0][3:0] dig;
    logic [3:0]      last;
    logic [15:0]     val;
    logic            vv;
    logic            ovf;
  } model_t;

  localparam model_t M_RST = '{brk: 1'b0, ext: 1'b0, cnt: 4'd0, dig: '0,
                               last: 4'hF, val: 16'h0, vv: 1'b0, ovf: 1'b0};

  localparam logic [7:0] KEY [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                      8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  function automatic logic [15:0] pack(model_t m);
    logic [15:0] e = '0;
    for (int i = 0; i < int'(m.cnt); i++) e[4*i +: 4] = m.dig[int'(m.cnt) - 1 - i];
    return e;
  endfunction

  function automatic model_t step(model_t m, logic v, logic [7:0] b, bit hex);
    model_t r = m;
    int     d = -1;
    bit     enter = 1'b0;
    r.vv = 1'b0;
    if (!v) return r;
    if (m.brk) r.brk = 1'b0;
    else if (m.ext) begin
      r.ext = 1'b0;
      if (b == 8'hF0)      r.brk = 1'b1;
      else if (b == 8'h5A) enter = 1'b1;
    end
    else if (b == 8'hF0) r.brk = 1'b1;
    else if (b == 8'hE0) r.ext = 1'b1;
    else if (b == 8'h5A) enter = 1'b1;
    else if (b == 8'h66) begin
      if (r.cnt > 0) begin
        r.cnt = r.cnt - 4'd1;
        r.dig[r.cnt] = 4'h0;
      end
    end
    else if (b == 8'h00) r.last = 4'hF;
    else begin
      for (int i = 0; i < 16; i++) if (KEY[i] == b && (i < 10 || hex)) d = i;
      if (d < 0) r.last = 4'hA;
      else begin
        r.last = 4'(d);
        if (int'(r.cnt) < N) begin
          r.dig[r.cnt] = 4'(d);
          r.cnt = r.cnt + 4'd1;
        end else r.ovf = 1'b1;
      end
    end
    if (enter) begin
      r.val = pack(m);
      r.vv  = 1'b1;
      r.cnt = 4'd0;
      r.dig = '0;
      r.ovf = 1'b0;
      r.last = 4'hF;
    end
    return r;
  endfunction

  model_t m0, m1;

  // Advance both models on the same edge the DUTs sample.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0 <= M_RST;
      m1 <= M_RST;
    end else begin
      m0 <= step(m0, sv, sc, 1'b0);
      m1 <= step(m1, sv, sc, 1'b1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against their models.
  always @(negedge clk) begin
    if (rst) begin
      check("dec.digit_out",   32'(bus0.digit_out),   32'(m0.last));
      check("dec.entry_out",   32'(bus0.entry_out),   32'(pack(m0)));
      check("dec.digit_count", 32'(bus0.digit_count), 32'(m0.cnt));
      check("dec.value_out",   32'(bus0.value_out),   32'(m0.val));
      check("dec.value_valid", 32'(bus0.value_valid), 32'(m0.vv));
      check("dec.overflow",    32'(bus0.overflow),    32'(m0.ovf));
      check("hex.digit_out",   32'(bus1.digit_out),   32'(m1.last));
      check("hex.entry_out",   32'(bus1.entry_out),   32'(pack(m1)));
      check("hex.digit_count", 32'(bus1.digit_count), 32'(m1.cnt));
      check("hex.value_out",   32'(bus1.value_out),   32'(m1.val));
      check("hex.value_valid", 32'(bus1.value_valid), 32'(m1.vv));
      check("hex.overflow",    32'(bus1.overflow),    32'(m1.ovf));
    end
  end

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    sc = b;
    sv = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    sv = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    put(b);
    idle();
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst.digit_out",   32'(bus0.digit_out),   32'hF);
    check("rst.entry_out",   32'(bus0.entry_out),   32'h0);
    check("rst.value_out",   32'(bus0.value_out),   32'h0);
    check("rst.digit_count", 32'(bus0.digit_count), 32'h0);
    check("rst.overflow",    32'(bus0.overflow),    32'h0);
    check("rst.value_valid", 32'(bus0.value_valid), 32'h0);

    // Two digits with releases, then commit
    send(8'h16); send(8'hF0); send(8'h16);
    send(8'h1E); send(8'hF0); send(8'h1E);
    check("t1.entry", 32'(bus0.entry_out),   32'h0012);
    check("t1.count", 32'(bus0.digit_count), 32'd2);
    send(8'h5A);
    check("t1.value", 32'(bus0.value_out),   32'h0012);
    check("t1.pulse", 32'(bus0.value_valid), 32'h1);
    check("t1.clear", 32'(bus0.entry_out),   32'h0);
    check("t1.digit", 32'(bus0.digit_out),   32'hF);
    idle();
    check("t1.pulse_end", 32'(bus0.value_valid), 32'h0);

    // Overflow, backspace, commit clears overflow
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    check("t2.entry", 32'(bus0.entry_out), 32'h1234);
    check("t2.ovf",   32'(bus0.overflow),  32'h1);
    check("t2.digit", 32'(bus0.digit_out), 32'h5);
    send(8'h66);
    check("t2.bs_entry", 32'(bus0.entry_out),   32'h0123);
    check("t2.bs_count", 32'(bus0.digit_count), 32'd3);
    check("t2.bs_ovf",   32'(bus0.overflow),    32'h1);
    send(8'h5A);
    check("t2.ovf_clr", 32'(bus0.overflow),  32'h0);
    check("t2.value",   32'(bus0.value_out), 32'h0123);

    // Keypad Enter commits; released keypad Enter does not
    send(8'hE0); send(8'h5A);
    check("t3.kp_pulse", 32'(bus0.value_valid), 32'h1);
    send(8'hE0); send(8'hF0); send(8'h5A);
    check("t3.kp_rel", 32'(bus0.value_valid), 32'h0);
    send(8'h16);
    check("t3.idle_again", 32'(bus0.entry_out), 32'h0001);
    send(8'h1C);
    check("t3.dec_A_digit", 32'(bus0.digit_out), 32'hA);
    check("t3.dec_A_entry", 32'(bus0.entry_out), 32'h0001);
    check("t3.hex_A_entry", 32'(bus1.entry_out), 32'h001A);
    send(8'hE0); send(8'h75);   // extended arrow key is dropped
    send(8'h1D);                // W: unrecognised
    check("t3.unknown", 32'(bus0.digit_out), 32'hA);
    send(8'h00);
    check("t3.null", 32'(bus0.digit_out), 32'hF);
    send(8'h5A);
    check("t3.hex_value", 32'(bus1.value_out), 32'h001A);

    // Backspace on empty entry; reset discards a pending break prefix
    send(8'h66);
    check("t4.bs_empty_entry", 32'(bus0.entry_out),   32'h0);
    check("t4.bs_empty_count", 32'(bus0.digit_count), 32'h0);
    check("t4.bs_empty_digit", 32'(bus0.digit_out),   32'hF);
    send(8'hF0);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send(8'h16);
    check("t4.after_rst_entry", 32'(bus0.entry_out), 32'h0001);
    check("t4.after_rst_digit", 32'(bus0.digit_out), 32'h1);
    send(8'h5A);

    // Back-to-back strobes
    put(8'h16);
    put(8'h1E);
    check("t5.first", 32'(bus0.entry_out), 32'h0001);
    idle();
    check("t5.both", 32'(bus0.entry_out), 32'h0012);

    // Two Enters in consecutive cycles pulse twice; zero entry commits zero
    put(8'h5A);
    put(8'h5A);
    check("t6.first_pulse", 32'(bus0.value_valid), 32'h1);
    idle();
    check("t6.second_pulse", 32'(bus0.value_valid), 32'h1);
    check("t6.zero_value",   32'(bus0.value_out),   32'h0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/scan_code_digit_entry.md
Name: scan_code_digit_entry

Overview:
- Sequential, parametrised successor to the combinational scan-code-to-digit lookup.
- Consumes a stream of PS/2 set-2 scan-code bytes and tracks break (F0) and extended (E0) prefixes.
- Decodes make codes into digits, accumulates up to NUM_DIGITS digits with backspace editing, and commits the entry on Enter.
- Sits between the PS/2 byte receiver and the display/arithmetic logic.

Parameters:
- NUM_DIGITS, 4, number of 4-bit digit slots held (1..8).
- HEX_EN, 0, 1 = keys A-F are also accepted as digits 10-15; 0 = decimal only.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- scan_code_in  in  8  received scan-code byte.
- scan_valid  in  1  one-cycle strobe; scan_code_in is valid in this cycle.
- digit_out  out  4  code of the last make key; 1111 = none since reset or commit, 1010 = unrecognised key (decimal mode).
- entry_out  out  4*NUM_DIGITS  digits being edited, newest digit in bits [3:0], unused slots zero.
- digit_count  out  clog2(NUM_DIGITS+1)  number of digits currently held.
- value_out  out  4*NUM_DIGITS  last committed entry.
- value_valid  out  1  one-cycle pulse when value_out updates.
- overflow  out  1  sticky; a digit was dropped because the entry was full.

Behaviour:
- Reset (rst=0, async) sets every output and register to zero, except digit_out = 1111; FSM goes to IDLE.
- Key map:
  - Digits: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - HEX_EN=1 only: 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F.
  - Control: 5A = Enter, 66 = Backspace, F0 = break prefix, E0 = extended prefix.
- FSM, advancing only in cycles where scan_valid=1:
  - IDLE:
    - F0 -> BRK.
    - E0 -> EXT.
    - Any other byte is a make code: act on it, stay in IDLE.
  - BRK: any byte is discarded -> IDLE. Key releases never produce input.
  - EXT:
    - F0 -> BRK.
    - 5A (keypad Enter) -> treated as Enter -> IDLE.
    - Any other byte is discarded -> IDLE.
  - No timeout: the FSM holds its state while scan_valid stays 0.
- Make actions, registered and visible the cycle after the scan_valid edge:
  - Digit, count < NUM_DIGITS:
    - entry_out <= {entry[4*NUM_DIGITS-5:0], d}; count += 1.
    - digit_out <= d.
  - Digit, count = NUM_DIGITS:
    - Entry unchanged; overflow <= 1.
    - digit_out <= d.
  - Backspace:
    - count > 0: entry_out <= entry >> 4, count -= 1.
    - count = 0: no-op.
    - digit_out unchanged.
  - Enter:
    - value_out <= entry_out, value_valid <= 1 for exactly one cycle.
    - entry_out, digit_count and overflow cleared; digit_out <= 1111.
    - Enter with count = 0 still commits a zero value and pulses.
  - Unrecognised make code, or A-F with HEX_EN=0: entry unchanged; digit_out <= 1010.
  - 00 as a make code: digit_out <= 1111; no other effect.
- Latency: one clock from the scan_valid cycle to the updated outputs. Back-to-back scan_valid on consecutive cycles is supported.
- value_valid is never high for two consecutive cycles unless two Enters arrive in consecutive cycles.
- Reset asserted mid-sequence (e.g. between F0 and its key byte) discards the pending prefix.

Test Plan:
- Reset with NUM_DIGITS=4, HEX_EN=0 -> digit_out=1111, entry_out=0000, value_out=0000, digit_count=0, overflow=0, value_valid=0.
- Bytes 16, F0 16, 1E, F0 1E, 5A -> entry_out=0x0012 with count 2 before Enter; then value_out=0x0012, one value_valid pulse, entry_out=0, digit_out=1111.
- Bytes 16 1E 26 25 2E (five digits) -> entry_out=0x1234, overflow=1, digit_out=0101. Then 66 -> entry_out=0x0123, count 3, overflow still 1. Then 5A -> overflow cleared.
- Bytes E0 5A -> commit (value_valid pulse). Bytes E0 F0 5A -> no commit, FSM back in IDLE. Byte 1C with HEX_EN=0 -> digit_out=1010, entry unchanged; with HEX_EN=1 -> digit A shifted in.
- Bytes 66 with count 0 -> no change. Bytes F0 then rst pulled low then high, then 16 -> digit 1 accepted (prefix discarded by reset).
- Bytes 16 and 1E on consecutive clock cycles -> both accepted; entry_out=0x0012 two cycles after the first strobe.
